// File: rtl/conv_sequencer.sv
// conv_sequencer: hardware sequencer for one 3x3 convolution pass over the
// column-stream datapath. It clears the convolver, loads the kernel column by
// column, streams image columns out of the three row BRAMs, and writes every
// complete window result back into BRAM 0 at its pipeline-delayed address.
module conv_sequencer #(
  parameter int BIT_LEN    = 8,
  parameter int NB_ADDRESS = 10,
  parameter int M_LEN      = 3,
  parameter int OUT_LAT    = 6
) (
  input  logic                            CLK100MHZ,
  input  logic                            i_reset_n,
  input  logic                            i_start,
  input  logic [NB_ADDRESS-1:0]           i_ncols,
  input  logic [M_LEN*M_LEN*BIT_LEN-1:0]  i_kernel,
  output logic                            o_conv_reset,
  output logic                            o_selecK_I,
  output logic                            o_valid,
  output logic [M_LEN*BIT_LEN-1:0]        o_kdata,
  output logic [NB_ADDRESS-1:0]           o_read_add,
  output logic [NB_ADDRESS-1:0]           o_write_add,
  output logic                            o_wr_enable,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  localparam int KERNEL_W = M_LEN * M_LEN * BIT_LEN;
  localparam int COL_W    = M_LEN * BIT_LEN;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    KLOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [NB_ADDRESS-1:0]   cnt;
  logic [NB_ADDRESS-1:0]   cnt_nxt;
  logic [NB_ADDRESS-1:0]   ncols_q;
  logic [KERNEL_W-1:0]     kernel_q;
  logic                    accept;
  logic                    error_nxt;

  logic                    conv_reset_nxt;
  logic                    selec_nxt;
  logic                    valid_nxt;
  logic [COL_W-1:0]        kdata_nxt;
  logic [NB_ADDRESS-1:0]   read_add_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic                    issue_nxt;
  logic                    wr_nxt;

  logic                    tag_vld  [OUT_LAT];
  logic [NB_ADDRESS-1:0]   tag_addr [OUT_LAT];

  // State and phase counter register; cnt is the index within the current phase
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic plus the values every output will take in the next cycle
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    accept         = 1'b0;
    error_nxt      = 1'b0;
    conv_reset_nxt = 1'b0;
    selec_nxt      = 1'b1;
    valid_nxt      = 1'b0;
    kdata_nxt      = '0;
    read_add_nxt   = '0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    issue_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_ncols >= NB_ADDRESS'(M_LEN)) begin
            accept    = 1'b1;
            state_nxt = CLR;
            cnt_nxt   = '0;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      CLR: begin
        state_nxt = KLOAD;
        cnt_nxt   = '0;
      end
      KLOAD: begin
        if (cnt == NB_ADDRESS'(M_LEN - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (cnt == ncols_q - NB_ADDRESS'(1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == NB_ADDRESS'(OUT_LAT - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = (state_nxt == DONE);
    conv_reset_nxt = (state_nxt == CLR);
    selec_nxt      = (state_nxt != KLOAD);
    valid_nxt      = (state_nxt == KLOAD) || (state_nxt == RUN) || (state_nxt == DRAIN);
    issue_nxt      = (state_nxt == RUN);

    if (state_nxt == KLOAD) begin
      for (int j = 0; j < M_LEN; j++) begin
        if (cnt_nxt == NB_ADDRESS'(j)) begin
          kdata_nxt = kernel_q[j*COL_W +: COL_W];
        end
      end
    end

    if (state_nxt == RUN) begin
      read_add_nxt = cnt_nxt;
    end else if (state_nxt == DRAIN) begin
      read_add_nxt = ncols_q - NB_ADDRESS'(1);
    end
  end

  // Capture the column count and kernel when a start is accepted
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ncols_q  <= '0;
      kernel_q <= '0;
    end else if (accept) begin
      ncols_q  <= i_ncols;
      kernel_q <= i_kernel;
    end
  end

  // Column-tag pipe: stage k holds the address issued k cycles ago
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < OUT_LAT; k++) begin
        tag_vld[k]  <= 1'b0;
        tag_addr[k] <= '0;
      end
    end else begin
      tag_vld[0]  <= issue_nxt;
      tag_addr[0] <= read_add_nxt;
      for (int k = 1; k < OUT_LAT; k++) begin
        tag_vld[k]  <= tag_vld[k-1];
        tag_addr[k] <= tag_addr[k-1];
      end
    end
  end

  // A tag leaving the pipe is a full window only once M_LEN columns have entered
  assign wr_nxt = tag_vld[OUT_LAT-1] && (tag_addr[OUT_LAT-1] >= NB_ADDRESS'(M_LEN - 1));

  // Output registers, loaded with the values decoded for the coming cycle
  always_ff @(posedge CLK100MHZ or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_conv_reset <= 1'b0;
      o_selecK_I   <= 1'b1;
      o_valid      <= 1'b0;
      o_kdata      <= '0;
      o_read_add   <= '0;
      o_write_add  <= '0;
      o_wr_enable  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_conv_reset <= conv_reset_nxt;
      o_selecK_I   <= selec_nxt;
      o_valid      <= valid_nxt;
      o_kdata      <= kdata_nxt;
      o_read_add   <= read_add_nxt;
      o_wr_enable  <= wr_nxt;
      o_busy       <= busy_nxt;
      o_done       <= done_nxt;
      o_error      <= error_nxt;
      if (wr_nxt) begin
        o_write_add <= tag_addr[OUT_LAT-1] - NB_ADDRESS'(M_LEN - 1);
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: table-driven bench for conv_sequencer with a few
// hand-written sequences for kernel loading and mid-pass reset.
module tb_conv_sequencer;

  logic          CLK100MHZ;
  logic          i_reset_n;
  logic          i_start;
  logic [9:0]    i_ncols;
  logic [71:0]   i_kernel;
  logic          o_conv_reset;
  logic          o_selecK_I;
  logic          o_valid;
  logic [23:0]   o_kdata;
  logic [9:0]    o_read_add;
  logic [9:0]    o_write_add;
  logic          o_wr_enable;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int ncols;
    int restart_cyc;
    int exp_err_cyc;
    int exp_done_cyc;
    int exp_writes;
    int exp_first_wr;
    int exp_last_wr;
    int exp_valid;
  } vec_t;

  typedef struct {
    int err_cyc;
    int done_cyc;
    int done_cnt;
    int busy_cnt;
    int valid_cnt;
    int writes;
    int first_wr;
    int last_wr;
    int wr_bad;
  } obs_t;

  localparam logic [50:0] RESET_VEC = {1'b0, 1'b1, 1'b0, 24'h0, 10'h0, 10'h0, 4'b0000};

  conv_sequencer dut (
    .CLK100MHZ    (CLK100MHZ),
    .i_reset_n    (i_reset_n),
    .i_start      (i_start),
    .i_ncols      (i_ncols),
    .i_kernel     (i_kernel),
    .o_conv_reset (o_conv_reset),
    .o_selecK_I   (o_selecK_I),
    .o_valid      (o_valid),
    .o_kdata      (o_kdata),
    .o_read_add   (o_read_add),
    .o_write_add  (o_write_add),
    .o_wr_enable  (o_wr_enable),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  // 100 MHz clock
  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic logic [50:0] pack_outputs();
    return {o_conv_reset, o_selecK_I, o_valid, o_kdata, o_read_add, o_write_add,
            o_wr_enable, o_busy, o_done, o_error};
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Start a pass at a falling edge and watch every cycle until DONE settles
  task automatic applyStimulus(input vec_t v, input logic [71:0] kern, output obs_t o);
    o = '{err_cyc: -1, done_cyc: -1, done_cnt: 0, busy_cnt: 0, valid_cnt: 0,
          writes: 0, first_wr: -1, last_wr: -1, wr_bad: 0};
    @(negedge CLK100MHZ);
    i_start  = 1'b1;
    i_ncols  = 10'(v.ncols);
    i_kernel = kern;
    for (int cyc = 1; cyc <= v.ncols + 45; cyc++) begin
      @(negedge CLK100MHZ);
      if (cyc == v.restart_cyc) begin
        i_start = 1'b1;
        i_ncols = 10'd5;
      end else begin
        i_start = 1'b0;
        i_ncols = 10'(v.ncols);
      end
      if (o_error && o.err_cyc < 0) o.err_cyc = cyc;
      if (o_done) begin
        if (o.done_cyc < 0) o.done_cyc = cyc;
        o.done_cnt++;
      end
      if (o_busy)  o.busy_cnt++;
      if (o_valid) o.valid_cnt++;
      if (o_wr_enable) begin
        if (o.writes == 0) o.first_wr = cyc;
        if (int'(o_write_add) != o.writes || cyc != o.first_wr + o.writes) o.wr_bad++;
        o.last_wr = cyc;
        o.writes++;
      end
      if (o.done_cyc >= 0 && cyc >= o.done_cyc + 3) break;
    end
    i_start = 1'b0;
  endtask

  vec_t        vecs [7];
  obs_t        obs;
  logic [23:0] exp_col [3];
  logic [71:0] ident_kernel;
  int          hits;
  bit          found;

  initial begin
    //          ncols restart err  done wr  first last valid
    vecs[0] = '{38,   0,      -1,  49,  36, 13,   48,  47};
    vecs[1] = '{3,    0,      -1,  14,  1,  13,   13,  12};
    vecs[2] = '{2,    0,       1,  -1,  0,  -1,   -1,  0};
    vecs[3] = '{0,    0,       1,  -1,  0,  -1,   -1,  0};
    vecs[4] = '{10,   0,      -1,  21,  8,  13,   20,  19};
    vecs[5] = '{4,    0,      -1,  15,  2,  13,   14,  13};
    vecs[6] = '{38,   20,     -1,  49,  36, 13,   48,  47};

    ident_kernel = 72'h000000_000100_000000;
    exp_col[0]   = 24'h332211;
    exp_col[1]   = 24'h665544;
    exp_col[2]   = 24'h998877;

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_ncols   = '0;
    i_kernel  = '0;
    repeat (3) @(negedge CLK100MHZ);
    checkOutput("reset_state", longint'(pack_outputs()), longint'(RESET_VEC));
    i_reset_n = 1'b1;
    @(negedge CLK100MHZ);
    checkOutput("idle_after_reset", longint'(pack_outputs()), longint'(RESET_VEC));

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], ident_kernel, obs);
      $display("[TB] vector %0d ncols=%0d", i, vecs[i].ncols);
      checkOutput("error_cycle", obs.err_cyc, vecs[i].exp_err_cyc);
      checkOutput("done_cycle", obs.done_cyc, vecs[i].exp_done_cyc);
      checkOutput("done_count", obs.done_cnt, (vecs[i].exp_done_cyc < 0) ? 0 : 1);
      checkOutput("busy_cycles", obs.busy_cnt, (vecs[i].exp_done_cyc < 0) ? 0 : vecs[i].exp_done_cyc);
      checkOutput("valid_cycles", obs.valid_cnt, vecs[i].exp_valid);
      checkOutput("write_count", obs.writes, vecs[i].exp_writes);
      checkOutput("first_write", obs.first_wr, vecs[i].exp_first_wr);
      checkOutput("last_write", obs.last_wr, vecs[i].exp_last_wr);
      checkOutput("write_sequence", obs.wr_bad, 0);
    end

    // Kernel load: clear in cycle 1, then one kernel column per cycle
    @(negedge CLK100MHZ);
    i_start  = 1'b1;
    i_ncols  = 10'd5;
    i_kernel = {exp_col[2], exp_col[1], exp_col[0]};
    @(negedge CLK100MHZ);
    i_start = 1'b0;
    checkOutput("clr_conv_reset", o_conv_reset, 1);
    checkOutput("clr_valid", o_valid, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK100MHZ);
      checkOutput($sformatf("kdata_col%0d", j), o_kdata, exp_col[j]);
      checkOutput($sformatf("kload_selec%0d", j), o_selecK_I, 0);
      checkOutput($sformatf("kload_valid%0d", j), o_valid, 1);
    end
    @(negedge CLK100MHZ);
    checkOutput("run_selec", o_selecK_I, 1);
    checkOutput("run_first_addr", o_read_add, 0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge CLK100MHZ);
      if (o_done) found = 1'b1;
    end
    checkOutput("kload_pass_done", found, 1);

    // Reset in the middle of RUN, at read address 10
    @(negedge CLK100MHZ);
    i_start  = 1'b1;
    i_ncols  = 10'd38;
    i_kernel = ident_kernel;
    found    = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge CLK100MHZ);
      i_start = 1'b0;
      if (o_valid && o_selecK_I && o_read_add == 10'd10) found = 1'b1;
    end
    checkOutput("reach_addr10", found, 1);
    #2 i_reset_n = 1'b0;
    #1 checkOutput("async_reset_state", longint'(pack_outputs()), longint'(RESET_VEC));
    repeat (3) @(negedge CLK100MHZ);
    i_reset_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK100MHZ);
      if (o_wr_enable || o_busy || o_valid) hits++;
    end
    checkOutput("quiet_after_reset", hits, 0);

    applyStimulus(vecs[0], ident_kernel, obs);
    checkOutput("rerun_done_cycle", obs.done_cyc, 49);
    checkOutput("rerun_write_count", obs.writes, 36);
    checkOutput("rerun_write_sequence", obs.wr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
